// File: rtl/main_rom_arbiter_if.sv
// CPU, loader and memory signal bundle for the program-ROM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface main_rom_arbiter_if #(
   parameter int AW = 18
);
   logic          CPUMX;
   logic [15:0]   CPUAD;
   logic [2:0]    BK;
   logic          CPU_WAIT;
   logic          ROMDV;
   logic [7:0]    ROMDT;

   logic          DLEN;
   logic          DLWR;
   logic [AW-1:0] DLAD;
   logic [7:0]    DLDT;
   logic          DL_BUSY;
   logic          DL_OVF;

   logic          MEM_REQ;
   logic          MEM_WE;
   logic [AW-1:0] MEM_AD;
   logic [7:0]    MEM_WD;
   logic          MEM_ACK;
   logic [7:0]    MEM_RD;

   modport slave (
      input  CPUMX, CPUAD, BK, DLEN, DLWR, DLAD, DLDT, MEM_ACK, MEM_RD,
      output CPU_WAIT, ROMDV, ROMDT, DL_BUSY, DL_OVF, MEM_REQ, MEM_WE, MEM_AD, MEM_WD
   );

   modport master (
      output CPUMX, CPUAD, BK, DLEN, DLWR, DLAD, DLDT, MEM_ACK, MEM_RD,
      input  CPU_WAIT, ROMDV, ROMDT, DL_BUSY, DL_OVF, MEM_REQ, MEM_WE, MEM_AD, MEM_WD
   );
endinterface

// File: rtl/main_rom_arbiter.sv
// Shares one single-port program memory between CPU ROM reads (through a
// one-entry read cache) and loader download writes, which take priority.
module main_rom_arbiter #(
   parameter int            AW        = 18,
   parameter logic [AW-1:0] BANK_BASE = AW'(18'h0C000)
) (
   input  logic              CL,
   input  logic              RESET_n,
   main_rom_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CPU_RD = 2'd1,
      S_DL_WR  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          valid_q, valid_d;
   logic [AW-1:0] tag_q, tag_d;
   logic [7:0]    data_q, data_d;
   logic          pending_q, pending_d;
   logic [AW-1:0] dl_ad_q, dl_ad_d;
   logic [7:0]    dl_dt_q, dl_dt_d;
   logic          ovf_q, ovf_d;
   logic          dlen_q, dlen_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_ad_q, mem_ad_d;
   logic [7:0]    mem_wd_q, mem_wd_d;

   logic          in_fixed;
   logic          in_bank;
   logic          rom_hit;
   logic [AW-1:0] phys;
   logic          hit;
   logic          fill;
   logic          pending_clr;
   logic          dlen_rise;

   // Address decode: fixed window maps 1:1, banked window is 8 x 2 KB pages.
   always_comb begin
      in_fixed = (bus.CPUAD < 16'hC000);
      in_bank  = (bus.CPUAD >= 16'hF800);
      rom_hit  = bus.CPUMX & ~bus.DLEN & (in_fixed | in_bank);
      phys     = in_fixed ? AW'(bus.CPUAD)
                          : BANK_BASE + AW'({bus.BK, bus.CPUAD[10:0]});
      hit      = rom_hit & valid_q & (tag_q == phys);
   end

   // Wait is forced low while reset is held so the CPU is released at once.
   assign bus.CPU_WAIT = RESET_n & rom_hit & ~hit;
   assign bus.ROMDV    = hit;
   assign bus.ROMDT    = hit ? data_q : 8'h00;
   assign bus.DL_BUSY  = pending_q;
   assign bus.DL_OVF   = ovf_q;
   assign bus.MEM_REQ  = mem_req_q;
   assign bus.MEM_WE   = mem_we_q;
   assign bus.MEM_AD   = mem_ad_q;
   assign bus.MEM_WD   = mem_wd_q;

   always_ff @(posedge CL or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q   <= S_IDLE;
         valid_q   <= 1'b0;
         tag_q     <= '0;
         data_q    <= '0;
         pending_q <= 1'b0;
         dl_ad_q   <= '0;
         dl_dt_q   <= '0;
         ovf_q     <= 1'b0;
         dlen_q    <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_ad_q  <= '0;
         mem_wd_q  <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         tag_q     <= tag_d;
         data_q    <= data_d;
         pending_q <= pending_d;
         dl_ad_q   <= dl_ad_d;
         dl_dt_q   <= dl_dt_d;
         ovf_q     <= ovf_d;
         dlen_q    <= dlen_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         mem_ad_q  <= mem_ad_d;
         mem_wd_q  <= mem_wd_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      pending_d   = pending_q;
      dl_ad_d     = dl_ad_q;
      dl_dt_d     = dl_dt_q;
      ovf_d       = ovf_q;
      dlen_d      = bus.DLEN;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_ad_d    = mem_ad_q;
      mem_wd_d    = mem_wd_q;
      fill        = 1'b0;
      pending_clr = 1'b0;
      dlen_rise   = bus.DLEN & ~dlen_q;

      // Address/data are loaded on state entry; REQ rises one cycle later,
      // which also guarantees an idle REQ gap between transactions.
      unique case (state_q)
         S_IDLE: begin
            if (pending_q) begin
               state_d  = S_DL_WR;
               mem_we_d = 1'b1;
               mem_ad_d = dl_ad_q;
               mem_wd_d = dl_dt_q;
            end else if (rom_hit && !hit) begin
               state_d  = S_CPU_RD;
               mem_we_d = 1'b0;
               mem_ad_d = phys;
               mem_wd_d = 8'h00;
            end
         end
         S_CPU_RD: begin
            if (!mem_req_q) begin
               mem_req_d = 1'b1;
            end else if (bus.MEM_ACK) begin
               mem_req_d = 1'b0;
               fill      = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_DL_WR: begin
            if (!mem_req_q) begin
               mem_req_d = 1'b1;
            end else if (bus.MEM_ACK) begin
               mem_req_d   = 1'b0;
               pending_clr = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      // The holding register frees up before capture, so a strobe that
      // coincides with the completing write is accepted.
      pending_d = pending_q & ~pending_clr;
      if (bus.DLWR) begin
         if (pending_d) begin
            ovf_d = 1'b1;
         end else begin
            pending_d = 1'b1;
            dl_ad_d   = bus.DLAD;
            dl_dt_d   = bus.DLDT;
         end
      end

      // A fill is kept only if no concurrent download touches that address.
      if (fill) begin
         tag_d   = mem_ad_q;
         data_d  = bus.MEM_RD;
         valid_d = ~dlen_rise & ~(bus.DLWR & (bus.DLAD == mem_ad_q));
      end else if (dlen_rise || (bus.DLWR && (bus.DLAD == tag_q))) begin
         valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_main_rom_arbiter.sv
// Self-checking bench for main_rom_arbiter: a memory responder pops expected
// requests from a scoreboard queue; scenario tasks check the CPU/loader side.
module tb_main_rom_arbiter;
   localparam int AW = 18;

   logic CL = 1'b0;
   logic RESET_n;
   always #5 CL = ~CL;

   main_rom_arbiter_if #(.AW(AW)) bus();

   main_rom_arbiter #(.AW(AW), .BANK_BASE(18'h0C000)) dut (
      .CL      (CL),
      .RESET_n (RESET_n),
      .bus     (bus)
   );

   typedef struct {
      logic [AW-1:0] ad;
      logic          we;
      logic [7:0]    wd;
   } txn_t;

   txn_t       exp_q[$];
   logic [7:0] mem_model [logic [AW-1:0]];
   int         checks    = 0;
   int         errors    = 0;
   int         ack_delay = 0;
   bit         mem_busy  = 0;

   function automatic logic [7:0] mem_read(input logic [AW-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a[7:0] ^ 8'h3C;
   endfunction

   task automatic push_txn(input logic [AW-1:0] ad, input logic we, input logic [7:0] wd);
      txn_t t;
      t.ad = ad;
      t.we = we;
      t.wd = wd;
      exp_q.push_back(t);
   endtask

   // Memory responder: one line per memory transaction.
   initial begin : responder
      txn_t          t;
      bit            req_prev;
      logic [AW-1:0] ad;
      logic          we;
      logic [7:0]    wd;
      req_prev    = 1'b0;
      bus.MEM_ACK = 1'b0;
      bus.MEM_RD  = 8'h00;
      forever begin
         @(negedge CL);
         bus.MEM_ACK = 1'b0;
         if (bus.MEM_REQ === 1'b1) begin
            ad = bus.MEM_AD;
            we = bus.MEM_WE;
            wd = bus.MEM_WD;
            mem_busy = 1'b1;
            checks++;
            if (req_prev) begin
               errors++;
               $display("FAIL req_gap: MEM_REQ=1 on cycle after ACK, required 0");
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_req: got ad=%h we=%0d, required no request", ad, we);
            end else begin
               t = exp_q.pop_front();
               if (ad !== t.ad || we !== t.we || (t.we && wd !== t.wd)) begin
                  errors++;
                  $display("FAIL mem_req: got ad=%h we=%0d wd=%h, required ad=%h we=%0d wd=%h",
                           ad, we, wd, t.ad, t.we, t.wd);
               end
            end
            repeat (ack_delay) @(negedge CL);
            if (we) mem_model[ad] = wd;
            else    bus.MEM_RD = mem_read(ad);
            $display("mem txn t=%0t %s ad=%h data=%h", $time, we ? "WR" : "RD", ad,
                     we ? wd : bus.MEM_RD);
            bus.MEM_ACK = 1'b1;
            mem_busy    = 1'b0;
            req_prev    = 1'b1;
         end else begin
            req_prev = 1'b0;
         end
      end
   end

   task automatic cpu_read(input logic [15:0] ad, input logic [2:0] bk, input bit exp_miss,
                           input logic [AW-1:0] exp_phys, input logic [7:0] exp_data,
                           input int exp_lat, input string name);
      int cyc;
      bit saw_req;
      @(negedge CL);
      if (exp_miss) push_txn(exp_phys, 1'b0, 8'h00);
      bus.CPUMX = 1'b1;
      bus.CPUAD = ad;
      bus.BK    = bk;
      #1;
      if (exp_miss) begin
         checks++;
         if (bus.CPU_WAIT !== 1'b1 || bus.ROMDV !== 1'b0) begin
            errors++;
            $display("FAIL %s_miss: got wait=%b dv=%b, required wait=1 dv=0", name, bus.CPU_WAIT, bus.ROMDV);
         end
         cyc = 0;
         while (bus.ROMDV !== 1'b1 && cyc < 64) begin
            @(negedge CL);
            #1;
            cyc++;
         end
         checks++;
         if (bus.ROMDV !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got dv=%b after %0d cycles, required 1", name, bus.ROMDV, cyc);
         end
         if (exp_lat >= 0) begin
            checks++;
            if (cyc != exp_lat) begin
               errors++;
               $display("FAIL %s_latency: got %0d wait cycles, required %0d", name, cyc, exp_lat);
            end
         end
      end else begin
         saw_req = 1'b0;
         repeat (3) begin
            @(negedge CL);
            if (bus.MEM_REQ === 1'b1) saw_req = 1'b1;
         end
         checks++;
         if (saw_req) begin
            errors++;
            $display("FAIL %s_noreq: got MEM_REQ=1 on a hit, required 0", name);
         end
      end
      checks++;
      if (bus.ROMDV !== 1'b1 || bus.CPU_WAIT !== 1'b0 || bus.ROMDT !== exp_data) begin
         errors++;
         $display("FAIL %s_data: got dv=%b wait=%b dt=%h, required dv=1 wait=0 dt=%h",
                  name, bus.ROMDV, bus.CPU_WAIT, bus.ROMDT, exp_data);
      end
      bus.CPUMX = 1'b0;
   endtask

   task automatic dl_write(input logic [AW-1:0] ad, input logic [7:0] dt, input bit exp_issue);
      @(negedge CL);
      if (exp_issue) push_txn(ad, 1'b1, dt);
      bus.DLWR = 1'b1;
      bus.DLAD = ad;
      bus.DLDT = dt;
      @(negedge CL);
      bus.DLWR = 1'b0;
   endtask

   task automatic wait_dl_idle(input string name);
      int cyc;
      cyc = 0;
      while (bus.DL_BUSY !== 1'b0 && cyc < 40) begin
         @(negedge CL);
         cyc++;
      end
      checks++;
      if (bus.DL_BUSY !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: got DL_BUSY=%b after %0d cycles, required 0", name, bus.DL_BUSY, cyc);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CL);
      bus.CPUMX = 1'b1;
      bus.CPUAD = 16'h0123;
      #1;
      checks++;
      if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_AD, bus.MEM_WD} !== '0) begin
         errors++;
         $display("FAIL reset_mem: got req=%b we=%b ad=%h wd=%h, required all 0",
                  bus.MEM_REQ, bus.MEM_WE, bus.MEM_AD, bus.MEM_WD);
      end
      checks++;
      if ({bus.CPU_WAIT, bus.ROMDV, bus.ROMDT, bus.DL_BUSY, bus.DL_OVF} !== '0) begin
         errors++;
         $display("FAIL reset_cpu: got wait=%b dv=%b dt=%h busy=%b ovf=%b, required all 0",
                  bus.CPU_WAIT, bus.ROMDV, bus.ROMDT, bus.DL_BUSY, bus.DL_OVF);
      end
      bus.CPUMX = 1'b0;
      @(negedge CL);
      RESET_n = 1'b1;
   endtask

   task automatic test_fixed_read();
      ack_delay = 2;
      cpu_read(16'h0123, 3'd0, 1'b1, 18'h00123, 8'hA5, 5, "fixed");
      cpu_read(16'h0123, 3'd0, 1'b0, 18'h00123, 8'hA5, -1, "fixed_hit");
   endtask

   task automatic test_banked_read();
      bit saw_req;
      ack_delay = 0;
      cpu_read(16'hBFFF, 3'd0, 1'b1, 18'h0BFFF, mem_read(18'h0BFFF), 3, "fixed_top");
      cpu_read(16'hF812, 3'd5, 1'b1, 18'h0E812, mem_read(18'h0E812), 3, "bank5");
      cpu_read(16'hF812, 3'd2, 1'b1, 18'h0D012, mem_read(18'h0D012), -1, "bank2");
      cpu_read(16'hF812, 3'd2, 1'b0, 18'h0D012, mem_read(18'h0D012), -1, "bank2_hit");
      @(negedge CL);
      bus.CPUMX = 1'b1;
      bus.CPUAD = 16'hC000;
      #1;
      checks++;
      if (bus.CPU_WAIT !== 1'b0 || bus.ROMDV !== 1'b0) begin
         errors++;
         $display("FAIL hole_c000: got wait=%b dv=%b, required 0 0", bus.CPU_WAIT, bus.ROMDV);
      end
      @(negedge CL);
      bus.CPUAD = 16'hF7FF;
      #1;
      checks++;
      if (bus.CPU_WAIT !== 1'b0 || bus.ROMDV !== 1'b0) begin
         errors++;
         $display("FAIL hole_f7ff: got wait=%b dv=%b, required 0 0", bus.CPU_WAIT, bus.ROMDV);
      end
      saw_req = 1'b0;
      repeat (3) begin
         @(negedge CL);
         if (bus.MEM_REQ === 1'b1) saw_req = 1'b1;
      end
      checks++;
      if (saw_req) begin
         errors++;
         $display("FAIL hole_noreq: got MEM_REQ=1 outside ROM windows, required 0");
      end
      bus.CPUMX = 1'b0;
   endtask

   task automatic test_download();
      ack_delay = 3;
      @(negedge CL);
      bus.DLEN = 1'b1;
      dl_write(18'h00010, 8'h3C, 1'b1);
      #1;
      checks++;
      if (bus.DL_BUSY !== 1'b1 || bus.DL_OVF !== 1'b0) begin
         errors++;
         $display("FAIL dl_first: got busy=%b ovf=%b, required busy=1 ovf=0", bus.DL_BUSY, bus.DL_OVF);
      end
      dl_write(18'h00011, 8'h4D, 1'b0);
      #1;
      checks++;
      if (bus.DL_BUSY !== 1'b1 || bus.DL_OVF !== 1'b1) begin
         errors++;
         $display("FAIL dl_drop: got busy=%b ovf=%b, required busy=1 ovf=1", bus.DL_BUSY, bus.DL_OVF);
      end
      wait_dl_idle("dl");
      repeat (6) @(negedge CL);
      checks++;
      if (bus.DL_OVF !== 1'b1 || mem_read(18'h00010) !== 8'h3C || mem_model.exists(18'h00011)) begin
         errors++;
         $display("FAIL dl_result: got ovf=%b mem10=%h mem11_written=%0d, required ovf=1 mem10=3c mem11_written=0",
                  bus.DL_OVF, mem_read(18'h00010), mem_model.exists(18'h00011));
      end
      bus.DLEN = 1'b0;
      cpu_read(16'hF812, 3'd2, 1'b1, 18'h0D012, mem_read(18'h0D012), -1, "dlen_inval");
   endtask

   task automatic test_tag_invalidate();
      ack_delay = 1;
      cpu_read(16'h0123, 3'd0, 1'b1, 18'h00123, 8'hA5, -1, "tag_fill");
      dl_write(18'h00124, 8'h11, 1'b1);
      wait_dl_idle("tag_other");
      cpu_read(16'h0123, 3'd0, 1'b0, 18'h00123, 8'hA5, -1, "tag_other_hit");
      dl_write(18'h00123, 8'h99, 1'b1);
      wait_dl_idle("tag_same");
      cpu_read(16'h0123, 3'd0, 1'b1, 18'h00123, 8'h99, -1, "tag_inval");
   endtask

   task automatic test_priority();
      int cyc;
      ack_delay = 2;
      @(negedge CL);
      push_txn(18'h00020, 1'b1, 8'h77);
      bus.DLEN = 1'b1;
      bus.DLWR = 1'b1;
      bus.DLAD = 18'h00020;
      bus.DLDT = 8'h77;
      @(negedge CL);
      push_txn(18'h00020, 1'b0, 8'h00);
      bus.DLWR  = 1'b0;
      bus.DLEN  = 1'b0;
      bus.CPUMX = 1'b1;
      bus.CPUAD = 16'h0020;
      bus.BK    = 3'd0;
      #1;
      checks++;
      if (bus.CPU_WAIT !== 1'b1 || bus.DL_BUSY !== 1'b1) begin
         errors++;
         $display("FAIL prio_start: got wait=%b busy=%b, required 1 1", bus.CPU_WAIT, bus.DL_BUSY);
      end
      cyc = 0;
      while (bus.ROMDV !== 1'b1 && cyc < 64) begin
         @(negedge CL);
         #1;
         cyc++;
      end
      checks++;
      if (bus.ROMDV !== 1'b1 || bus.ROMDT !== 8'h77 || cyc != 10) begin
         errors++;
         $display("FAIL prio_read: got dv=%b dt=%h after %0d cycles, required dv=1 dt=77 after 10",
                  bus.ROMDV, bus.ROMDT, cyc);
      end
      bus.CPUMX = 1'b0;
   endtask

   task automatic test_reset_abort();
      int cyc;
      ack_delay = 5;
      @(negedge CL);
      push_txn(18'h00456, 1'b0, 8'h00);
      bus.CPUMX = 1'b1;
      bus.CPUAD = 16'h0456;
      bus.BK    = 3'd0;
      cyc = 0;
      while (bus.MEM_REQ !== 1'b1 && cyc < 10) begin
         @(negedge CL);
         cyc++;
      end
      checks++;
      if (bus.MEM_REQ !== 1'b1) begin
         errors++;
         $display("FAIL abort_req: got MEM_REQ=%b, required 1", bus.MEM_REQ);
      end
      #2;
      RESET_n = 1'b0;
      #1;
      checks++;
      if (bus.MEM_REQ !== 1'b0 || bus.CPU_WAIT !== 1'b0 || bus.DL_OVF !== 1'b0 || bus.DL_BUSY !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: got req=%b wait=%b ovf=%b busy=%b, required all 0",
                  bus.MEM_REQ, bus.CPU_WAIT, bus.DL_OVF, bus.DL_BUSY);
      end
      bus.CPUMX = 1'b0;
      @(negedge CL);
      RESET_n = 1'b1;
      cyc = 0;
      while (mem_busy && cyc < 20) begin
         @(negedge CL);
         cyc++;
      end
      checks++;
      if (mem_busy) begin
         errors++;
         $display("FAIL abort_late_ack: responder still busy after %0d cycles, required idle", cyc);
      end
      repeat (2) @(negedge CL);
      cpu_read(16'h0456, 3'd0, 1'b1, 18'h00456, mem_read(18'h00456), -1, "after_abort");
   endtask

   initial begin
      RESET_n   = 1'b0;
      bus.CPUMX = 1'b0;
      bus.CPUAD = 16'h0000;
      bus.BK    = 3'd0;
      bus.DLEN  = 1'b0;
      bus.DLWR  = 1'b0;
      bus.DLAD  = '0;
      bus.DLDT  = 8'h00;
      mem_model[18'h00123] = 8'hA5;

      test_reset();
      test_fixed_read();
      test_banked_read();
      test_download();
      test_tag_invalidate();
      test_priority();
      test_reset_abort();

      repeat (4) @(negedge CL);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d requests never issued, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/main_rom_arbiter.md
Name: main_rom_arbiter

Overview:
- Shares one single-port program memory between two requesters: main-CPU instruction/data reads, and ROM-download writes from the loader.
- Maps the CPU's fixed and banked ROM windows to physical memory addresses.
- Holds the CPU with a wait signal while a read is outstanding.
- Sits between the main CPU bus (CPUMX/CPUAD, bank select) and the external memory; its ROMDV/ROMDT outputs feed the CPU data selector.

Parameters:
- AW, 18, physical memory address width.
- BANK_BASE, 18'h0C000, physical base address of the banked window.

Ports:
- CL  in  1  clock; all logic on the rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- CPUMX  in  1  CPU memory cycle active (high).
- CPUAD  in  16  CPU address.
- BK  in  3  ROM bank select.
- CPU_WAIT  out  1  high = stall the CPU.
- ROMDV  out  1  ROMDT is valid for the current CPU address.
- ROMDT  out  8  ROM read data.
- DLEN  in  1  download active.
- DLWR  in  1  single-cycle download write strobe.
- DLAD  in  AW  download address.
- DLDT  in  8  download data.
- DL_BUSY  out  1  download holding register is full.
- DL_OVF  out  1  sticky flag: a download write was dropped.
- MEM_REQ  out  1  memory request.
- MEM_WE  out  1  1 = write, 0 = read.
- MEM_AD  out  AW  memory address.
- MEM_WD  out  8  memory write data.
- MEM_ACK  in  1  one-cycle completion pulse.
- MEM_RD  in  8  read data, valid with MEM_ACK.

Behaviour:
- Reset: asserting RESET_n low immediately and asynchronously clears all registers.
  - All outputs go to 0; FSM goes to IDLE; cache becomes invalid; pending and DL_OVF clear.
  - Reset asserted mid-transaction abandons the transaction; a late MEM_ACK after reset is ignored.
- Decode (combinational):
  - rom_hit = CPUMX & ~DLEN & (CPUAD < 16'hC000 | CPUAD >= 16'hF800).
  - Physical address, fixed window (CPUAD < C000): zero-extended CPUAD.
  - Physical address, banked window: BANK_BASE + {BK, CPUAD[10:0]}; 8 banks of 2 KB.
- Read cache: one entry holding valid, tag[AW], data[8].
  - hit = rom_hit & valid & (tag == phys).
  - ROMDV = hit; ROMDT = hit ? data : 8'h00.
  - CPU_WAIT = rom_hit & ~hit, combinational, so it asserts in the same cycle as the miss.
  - A bank change alters phys and therefore misses naturally.
- Download capture:
  - DLWR with pending = 0: latch DLAD/DLDT into the holding register and set pending.
  - DLWR with pending = 1: the write is dropped and DL_OVF is set. DL_OVF clears only on reset.
  - DL_BUSY = pending.
- FSM states: IDLE, CPU_RD, DL_WR.
  - IDLE: if pending, go to DL_WR (loader has priority). Otherwise, if rom_hit & ~hit, go to CPU_RD and register phys as the request address.
  - The request is issued on the cycle after the state is entered; MEM_REQ, MEM_WE, MEM_AD and MEM_WD are registered and held stable until MEM_ACK.
  - CPU_RD: MEM_WE = 0. On MEM_ACK: data <= MEM_RD, tag <= request address, valid <= 1, MEM_REQ <= 0, go to IDLE.
    - The cache fills with the requested address even if CPUAD has changed meanwhile.
    - The hit appears on the cycle after ACK, and CPU_WAIT drops then.
  - DL_WR: MEM_WE = 1. On MEM_ACK: pending <= 0, MEM_REQ <= 0, go to IDLE.
  - A DLWR on the same cycle as the ACK is captured, because pending clears first.
- Minimum miss latency: miss cycle + request issue + ACK cycle + hit cycle = 3 cycles of CPU_WAIT when ACK returns on the first request cycle.
- Cache invalidation (valid <= 0):
  - A DLWR whose DLAD equals tag.
  - A rising edge of DLEN.
  - On the same cycle as a CPU_RD fill, the fill wins only if its address differs from DLAD.
- Back-to-back requests: MEM_REQ drops for at least one cycle between transactions.

Test Plan:
- Reset, then CPUMX = 1, CPUAD = 16'h0123, memory ACKs 2 cycles after request with 8'hA5 -> MEM_AD = 18'h00123, MEM_WE = 0, CPU_WAIT high until the cycle after ACK; then ROMDV = 1, ROMDT = 8'hA5. A repeat access to 0123 gives no MEM_REQ.
- BK = 3'd5, CPUAD = 16'hF812 -> MEM_AD = 18'h0C000 + 18'h2812 = 18'h0E812. Change BK to 3'd2 -> miss, MEM_AD = 18'h0D012.
- DLEN = 1, DLWR pulses at 18'h00010/8'h3C and 18'h00011/8'h4D spaced 1 cycle apart with ACK delay 3 -> first write issued, second dropped, DL_OVF = 1, DL_BUSY high until first ACK.
- Cache holds tag 18'h00123; DLWR to 18'h00123 -> valid cleared; next CPU access to 0123 misses and re-reads.
- Pending DL write and CPU miss raised in the same IDLE cycle -> DL_WR is serviced first; CPU_RD is issued after DL ACK plus 1 idle cycle.
- RESET_n pulsed low during CPU_RD with MEM_REQ high -> MEM_REQ and CPU_WAIT drop immediately; an ACK arriving afterwards does not set valid.
